// File: rtl/la_step_sequencer.sv
// LA-paced register-under-test sequencer: write, settle, read back and compare
// one step at a time, publishing step index and status to GPIO.
module la_step_sequencer #(
  parameter int NUM_STEPS     = 32,
  parameter int STEP_W        = 6,
  parameter int DATA_W        = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rstn_i,
  input  logic              la_start,
  input  logic              la_ack,
  input  logic [DATA_W-1:0] la_seed,
  output logic              dut_wr_en,
  output logic [DATA_W-1:0] dut_wdata,
  input  logic [DATA_W-1:0] dut_rdata,
  input  logic              dut_err,
  output logic [STEP_W-1:0] step_o,
  output logic [1:0]        status_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [7:0]        fail_count_o
);

  // state   | meaning
  // IDLE    | waiting for first start edge after reset
  // WRITE   | one-cycle write strobe to register-under-test
  // SETTLE  | wait SETTLE_CYCLES before sampling readback
  // CHECK   | compare readback and voter flag
  // REPORT  | status published, waiting for la_ack high
  // RELEASE | status cleared, waiting for la_ack low
  // DONE    | run complete, waiting for next start edge
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WRITE   = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_CHECK   = 3'd3;
  localparam logic [2:0] S_REPORT  = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS);

  logic [2:0]        state_q, state_d;
  logic              start_prev_q;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [1:0]        status_q, status_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        fail_q, fail_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              start_edge;

  // Seed rotated left by (step-1) mod DATA_W, then XOR the step index.
  function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] seed,
                                                input logic [STEP_W-1:0] step);
    logic [2*DATA_W-1:0] dbl;
    int unsigned         rot;
    rot = (32'(step) + 32'(DATA_W) - 32'd1) % 32'(DATA_W);
    dbl = {seed, seed} << rot;
    return dbl[2*DATA_W-1:DATA_W] ^ DATA_W'(step);
  endfunction

  assign start_edge = la_start & ~start_prev_q;

  always_comb begin
    state_d  = state_q;
    seed_d   = seed_q;
    step_d   = step_q;
    status_d = status_q;
    busy_d   = busy_q;
    done_d   = done_q;
    wr_en_d  = 1'b0;
    wdata_d  = wdata_q;
    fail_d   = fail_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_edge) begin
          seed_d   = la_seed;
          step_d   = STEP_W'(1);
          fail_d   = 8'd0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          status_d = 2'b00;
          wr_en_d  = 1'b1;
          wdata_d  = pattern(la_seed, STEP_W'(1));
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_CHECK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_CHECK: begin
        if (dut_err)                  status_d = 2'b11;
        else if (dut_rdata != wdata_q) status_d = 2'b10;
        else                          status_d = 2'b01;
        if ((dut_err || (dut_rdata != wdata_q)) && (fail_q != 8'hFF))
          fail_d = fail_q + 8'd1;
        state_d = S_REPORT;
      end
      S_REPORT: begin
        if (la_ack) begin
          status_d = 2'b00;
          state_d  = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!la_ack) begin
          if (step_q == LAST_STEP) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            step_d  = step_q + 1'b1;
            wr_en_d = 1'b1;
            wdata_d = pattern(seed_q, step_d);
            state_d = S_WRITE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      seed_q       <= '0;
      step_q       <= '0;
      status_q     <= 2'b00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wdata_q      <= '0;
      fail_q       <= 8'd0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= la_start;
      seed_q       <= seed_d;
      step_q       <= step_d;
      status_q     <= status_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      wr_en_q      <= wr_en_d;
      wdata_q      <= wdata_d;
      fail_q       <= fail_d;
      cnt_q        <= cnt_d;
    end
  end

  assign dut_wr_en    = wr_en_q;
  assign dut_wdata    = wdata_q;
  assign step_o       = step_q;
  assign status_o     = status_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign fail_count_o = fail_q;

endmodule

// File: tb/tb_la_step_sequencer.sv
// Directed bench for la_step_sequencer: loopback runs with injected mismatch,
// voter error, held ack, ignored start and mid-run reset.
module tb_la_step_sequencer;

  localparam int NUM = 32;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        la_start = 1'b0;
  logic        la_ack = 1'b0;
  logic [31:0] la_seed = 32'h0;
  logic        dut_wr_en;
  logic [31:0] dut_wdata;
  logic [31:0] dut_rdata;
  logic        dut_err;
  logic [5:0]  step_o;
  logic [1:0]  status_o;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  fail_count_o;

  int checks = 0;
  int failures = 0;
  int flip_step = 0;
  int err_step = 0;

  la_step_sequencer dut (
    .wb_clk_i     (clk),
    .wb_rstn_i    (rstn),
    .la_start     (la_start),
    .la_ack       (la_ack),
    .la_seed      (la_seed),
    .dut_wr_en    (dut_wr_en),
    .dut_wdata    (dut_wdata),
    .dut_rdata    (dut_rdata),
    .dut_err      (dut_err),
    .step_o       (step_o),
    .status_o     (status_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .fail_count_o (fail_count_o)
  );

  always #5 clk = ~clk;

  // Loopback register-under-test with per-step fault injection.
  assign dut_rdata = dut_wdata ^ ((int'(step_o) == flip_step) ? 32'h1 : 32'h0);
  assign dut_err   = (err_step != 0) && (int'(step_o) == err_step);

  function automatic logic [31:0] model_wd(input logic [31:0] s, input int step);
    int r;
    logic [31:0] rot;
    r = (step - 1) % 32;
    rot = (r == 0) ? s : ((s << r) | (s >> (32 - r)));
    return rot ^ 32'(step);
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    la_start = 1'b1;
    @(negedge clk);
    la_start = 1'b0;
  endtask

  // Wait for a report, capture it, then handshake it away. Timeouts flagged via 'to'.
  task automatic do_step(output int st, output logic [1:0] stat, output logic [31:0] wd,
                         output bit to);
    int n;
    to = 1'b0;
    n = 0;
    while (status_o == 2'b00 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      to = 1'b1; st = 0; stat = 2'b00; wd = 32'h0;
      return;
    end
    st = int'(step_o);
    stat = status_o;
    wd = dut_wdata;
    la_ack = 1'b1;
    n = 0;
    while (status_o != 2'b00 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) to = 1'b1;
    la_ack = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({dut_wr_en, dut_wdata, step_o, status_o, busy_o, done_o, fail_count_o} !== '0) begin
      failures++;
      $display("FAIL reset_hold: outputs=%h required 0",
               {dut_wr_en, dut_wdata, step_o, status_o, busy_o, done_o, fail_count_o});
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({dut_wr_en, dut_wdata, step_o, status_o, busy_o, done_o, fail_count_o} !== '0) begin
      failures++;
      $display("FAIL reset_idle: outputs=%h required 0",
               {dut_wr_en, dut_wdata, step_o, status_o, busy_o, done_o, fail_count_o});
    end
  endtask

  task automatic test_loopback();
    int st; logic [1:0] stat; logic [31:0] wd; bit to;
    la_seed = 32'h0000_0001;
    pulse_start();
    checks++;
    if (step_o !== 6'd1 || busy_o !== 1'b1 || done_o !== 1'b0 || dut_wr_en !== 1'b1) begin
      failures++;
      $display("FAIL loop_start: step=%0d busy=%b done=%b wr_en=%b required 1 1 0 1",
               step_o, busy_o, done_o, dut_wr_en);
    end
    for (int i = 1; i <= NUM; i++) begin
      do_step(st, stat, wd, to);
      checks++;
      if (to || st != i || stat !== 2'b01 || wd !== model_wd(32'h1, i)) begin
        failures++;
        $display("FAIL loop_step%0d: to=%b step=%0d status=%b wdata=%h required step=%0d status=01 wdata=%h",
                 i, to, st, stat, wd, i, model_wd(32'h1, i));
      end
      if (i == 2) begin
        checks++;
        if (wd !== 32'h0000_0000) begin
          failures++;
          $display("FAIL loop_step2_wdata: wdata=%h required 00000000", wd);
        end
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || fail_count_o !== 8'd0 || step_o !== 6'd32 ||
        status_o !== 2'b00) begin
      failures++;
      $display("FAIL loop_done: done=%b busy=%b fails=%0d step=%0d status=%b required 1 0 0 32 00",
               done_o, busy_o, fail_count_o, step_o, status_o);
    end
  endtask

  task automatic test_mismatch();
    int st; logic [1:0] stat; logic [31:0] wd; bit to;
    logic [1:0] exp;
    flip_step = 5;
    la_seed = 32'hA5A5_0F0F;
    pulse_start();
    la_seed = 32'hFFFF_0000;
    for (int i = 1; i <= NUM; i++) begin
      exp = (i == 5) ? 2'b10 : 2'b01;
      do_step(st, stat, wd, to);
      checks++;
      if (to || st != i || stat !== exp || wd !== model_wd(32'hA5A5_0F0F, i)) begin
        failures++;
        $display("FAIL mism_step%0d: to=%b step=%0d status=%b wdata=%h required step=%0d status=%b wdata=%h",
                 i, to, st, stat, wd, i, exp, model_wd(32'hA5A5_0F0F, i));
      end
    end
    flip_step = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (done_o !== 1'b1 || fail_count_o !== 8'd1) begin
      failures++;
      $display("FAIL mism_done: done=%b fails=%0d required 1 1", done_o, fail_count_o);
    end
  endtask

  task automatic test_voter_err();
    int st; logic [1:0] stat; logic [31:0] wd; bit to;
    logic [1:0] exp;
    err_step = 7;
    la_seed = 32'h8000_0003;
    pulse_start();
    for (int i = 1; i <= NUM; i++) begin
      exp = (i == 7) ? 2'b11 : 2'b01;
      do_step(st, stat, wd, to);
      checks++;
      if (to || st != i || stat !== exp) begin
        failures++;
        $display("FAIL voter_step%0d: to=%b step=%0d status=%b required step=%0d status=%b",
                 i, to, st, stat, i, exp);
      end
    end
    err_step = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (done_o !== 1'b1 || fail_count_o !== 8'd1) begin
      failures++;
      $display("FAIL voter_done: done=%b fails=%0d required 1 1", done_o, fail_count_o);
    end
  endtask

  task automatic test_ack_held();
    int st; logic [1:0] stat; logic [31:0] wd; bit to;
    la_seed = 32'h0000_0001;
    pulse_start();
    la_ack = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (step_o !== 6'd1 || status_o !== 2'b00 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL ack_held_stall: step=%0d status=%b busy=%b required 1 00 1",
               step_o, status_o, busy_o);
    end
    la_ack = 1'b0;
    for (int i = 2; i <= NUM; i++) begin
      do_step(st, stat, wd, to);
      checks++;
      if (to || st != i || stat !== 2'b01) begin
        failures++;
        $display("FAIL ack_held_step%0d: to=%b step=%0d status=%b required step=%0d status=01",
                 i, to, st, stat, i);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done_o !== 1'b1 || fail_count_o !== 8'd0) begin
      failures++;
      $display("FAIL ack_held_done: done=%b fails=%0d required 1 0", done_o, fail_count_o);
    end
  endtask

  task automatic test_start_ignored();
    int st; logic [1:0] stat; logic [31:0] wd; bit to;
    flip_step = 20;
    la_seed = 32'h0000_0001;
    pulse_start();
    for (int i = 1; i <= NUM; i++) begin
      if (i == 10) pulse_start();
      do_step(st, stat, wd, to);
      checks++;
      if (to || st != i || stat !== ((i == 20) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL start_ign_step%0d: to=%b step=%0d status=%b required step=%0d",
                 i, to, st, stat, i);
      end
    end
    flip_step = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (done_o !== 1'b1 || fail_count_o !== 8'd1) begin
      failures++;
      $display("FAIL start_ign_done: done=%b fails=%0d required 1 1", done_o, fail_count_o);
    end
    pulse_start();
    checks++;
    if (step_o !== 6'd1 || fail_count_o !== 8'd0 || busy_o !== 1'b1 || done_o !== 1'b0) begin
      failures++;
      $display("FAIL restart: step=%0d fails=%0d busy=%b done=%b required 1 0 1 0",
               step_o, fail_count_o, busy_o, done_o);
    end
  endtask

  task automatic test_reset_mid_run();
    int st; logic [1:0] stat; logic [31:0] wd; bit to;
    int n;
    for (int i = 1; i <= 11; i++) do_step(st, stat, wd, to);
    n = 0;
    while (!dut_wr_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (n >= 100 || step_o !== 6'd12 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre_reset: step=%0d busy=%b waited=%0d required step 12 busy 1",
               step_o, busy_o, n);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({dut_wr_en, dut_wdata, step_o, status_o, busy_o, done_o, fail_count_o} !== '0) begin
      failures++;
      $display("FAIL mid_async_reset: outputs=%h required 0",
               {dut_wr_en, dut_wdata, step_o, status_o, busy_o, done_o, fail_count_o});
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (step_o !== 6'd0 || busy_o !== 1'b0 || done_o !== 1'b0 || dut_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL mid_idle: step=%0d busy=%b done=%b wr_en=%b required 0 0 0 0",
               step_o, busy_o, done_o, dut_wr_en);
    end
    la_seed = 32'h1234_5678;
    pulse_start();
    checks++;
    if (step_o !== 6'd1 || busy_o !== 1'b1 || dut_wr_en !== 1'b1 || dut_wdata !== 32'h1234_5679) begin
      failures++;
      $display("FAIL mid_fresh_run: step=%0d busy=%b wr_en=%b wdata=%h required 1 1 1 12345679",
               step_o, busy_o, dut_wr_en, dut_wdata);
    end
    do_step(st, stat, wd, to);
    checks++;
    if (to || st != 1 || stat !== 2'b01) begin
      failures++;
      $display("FAIL mid_fresh_step1: to=%b step=%0d status=%b required step 1 status 01",
               to, st, stat);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_mismatch();
    test_voter_err();
    test_ack_held();
    test_start_ignored();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/la_step_sequencer.md
Name: la_step_sequencer

Overview:
- Logic-analyser-driven test sequencer inside the user project area.
- Steps a register-under-test (TMR-protected datapath) through NUM_STEPS write/settle/readback/compare cycles.
- Publishes the current step index and a 2-bit status on user GPIOs (step to mprj_io[25:20], status to mprj_io[37:36]).
- Advances only under management-SoC acknowledge over the LA bus, so firmware and an external bench can lock-step on each step.

Parameters:
- NUM_STEPS, 32, number of test steps per run (1..2^STEP_W-1).
- STEP_W, 6, width of the step index output.
- DATA_W, 32, width of the register-under-test data path.
- SETTLE_CYCLES, 4, clock cycles between write and readback sample (>=1).

Ports:
- wb_clk_i  input  1  user-area clock.
- wb_rstn_i  input  1  asynchronous active-low reset.
- la_start  input  1  run request from LA; rising edge starts a run.
- la_ack  input  1  step acknowledge from LA (level).
- la_seed  input  DATA_W  base test pattern, sampled at start.
- dut_wr_en  output  1  one-cycle write strobe to register-under-test.
- dut_wdata  output  DATA_W  write data to register-under-test.
- dut_rdata  input  DATA_W  readback from register-under-test.
- dut_err  input  1  TMR voter mismatch flag from register-under-test.
- step_o  output  STEP_W  current step index (0 = idle).
- status_o  output  2  00 idle/released, 01 pass, 10 data mismatch, 11 voter error.
- busy_o  output  1  high from start until DONE.
- done_o  output  1  high in DONE until next start.
- fail_count_o  output  8  failing steps in the current run, saturating at 255.

Behaviour:
- Reset (async assert, sync deassert): state IDLE; all outputs 0; seed register 0; start edge detector cleared.
- la_start edge detect: registered previous value. A rising edge is honoured only in IDLE or DONE; it is ignored while busy.
- FSM states:
  - IDLE -> WRITE on start edge: latch seed, step_o=1, fail_count=0, busy_o=1, done_o=0.
  - WRITE (1 cycle): dut_wr_en=1; dut_wdata = seed rotated left by (step_o-1) mod DATA_W, XOR step_o zero-extended. dut_wdata is held stable through CHECK. -> SETTLE.
  - SETTLE: counter runs SETTLE_CYCLES cycles, then -> CHECK.
  - CHECK (1 cycle): sample dut_rdata and dut_err.
    - dut_err=1: status 11, priority over mismatch.
    - else dut_rdata != dut_wdata: status 10.
    - else: status 01.
    - Any non-01 result increments fail_count (saturating). -> REPORT.
  - REPORT: status_o held; step_o held. la_ack=1 (including already high on entry, same cycle) -> RELEASE.
  - RELEASE: status_o=00, step_o held. On la_ack=0: if step_o==NUM_STEPS -> DONE; else step_o+1 -> WRITE.
  - DONE: busy_o=0, done_o=1, step_o=NUM_STEPS, status_o=00, fail_count held. Start edge -> same as IDLE start.
- status_o is never 00 between CHECK and ack, so 00 after a non-zero step uniquely signals release.
- Status and step change only on state transitions. All outputs are registered; there are no combinational LA-to-GPIO paths.
- Reset mid-run aborts immediately to IDLE; no partial write is retried.
- la_seed changes after start have no effect until the next run.

Test Plan:
- Loopback dut_rdata=dut_wdata, dut_err=0, seed 0x0000_0001, bench acks each step.
  -> step_o walks 1..32, each showing status 01 then 00.
  -> step 2 dut_wdata 0x0000_0000 (0x2 XOR 0x2).
  -> done_o=1, fail_count_o=0, busy_o=0.
- Loopback, but at step 5 force dut_rdata bit0 flipped.
  -> step 5 status 10, all others 01.
  -> fail_count_o=1 at DONE.
- Assert dut_err at step 7 CHECK with matching data.
  -> status 11 at step 7, fail_count_o=1.
  -> run continues normally after ack.
- Hold la_ack=1 continuously.
  -> sequencer stalls in RELEASE at step 1, status 00, until la_ack drops.
  -> then advances one step per ack pulse.
- Pulse la_start at step 10.
  -> ignored, step sequence unchanged.
  -> new rising edge after DONE restarts at step 1 with fail_count_o cleared.
- Drop wb_rstn_i during SETTLE of step 12.
  -> all outputs 0 asynchronously.
  -> after release, IDLE; start edge begins a fresh run at step 1.
